// File: rtl/ptw_mem_arbiter.sv
// ptw_mem_arbiter: shares one memory port between the page-table walker and the LSU.
// The walker wins ties, and a hung memory is cut off after TIMEOUT cycles with a zero, errored response.
module ptw_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_all,
    input  logic        lfm_enable,
    input  logic [31:0] lfm_addr,
    output logic        lfm_resolved,
    output logic [31:0] lfm_word,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    output logic        lsu_ack,
    output logic [31:0] lsu_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        bus_err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MEM, RESP, DRAIN} state_t;
    state_t      state, next;
    logic        owner_mmu, we, err;
    logic [31:0] addr, wdata, data;
    logic [3:0]  wstrb;
    logic [7:0]  cnt;
    logic        tmo, done, accept, resp;
    assign tmo    = !mem_ready && cnt == 8'(TIMEOUT - 1);
    assign done   = mem_ready || tmo;
    assign accept = state == IDLE && !flush_all && (lfm_enable || lsu_req);
    assign resp   = state == RESP && !flush_all;
    assign mem_req      = state == MEM || state == DRAIN;
    assign mem_we       = mem_req && we;
    assign mem_wstrb    = mem_req ? wstrb : 4'b0000;
    assign mem_addr     = addr;
    assign mem_wdata    = wdata;
    assign lfm_resolved = resp && owner_mmu;
    assign lsu_ack      = resp && !owner_mmu;
    assign bus_err      = resp && err;
    assign lfm_word     = data;
    assign lsu_rdata    = data;
    assign busy         = state != IDLE;
    always_ff @(posedge clk)
        state <= rst ? IDLE : next;
    // A flush that lands on the completing cycle has nothing left to drain.
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = accept ? MEM : IDLE;
            MEM:     next = done ? (flush_all ? IDLE : RESP) : (flush_all ? DRAIN : MEM);
            RESP:    next = IDLE;
            DRAIN:   next = done ? IDLE : DRAIN;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_mmu <= 1'b0;
            we        <= 1'b0;
            err       <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            data      <= '0;
            cnt       <= '0;
        end else begin
            if (accept) begin
                owner_mmu <= lfm_enable;
                we        <= !lfm_enable && lsu_we;
                addr      <= lfm_enable ? lfm_addr : lsu_addr;
                wdata     <= lfm_enable ? 32'h0 : lsu_wdata;
                wstrb     <= lfm_enable ? 4'b0000 : lsu_wstrb;
                err       <= 1'b0;
            end
            if (mem_req)
                cnt <= done ? 8'd0 : cnt + 8'd1;
            if (state == MEM && done) begin
                data <= (tmo || we) ? 32'h0 : mem_rdata;
                err  <= tmo;
            end
        end
    end
endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// tb_ptw_mem_arbiter: scoreboard bench with a delay-programmable memory model.
module tb_ptw_mem_arbiter;
    logic        clk = 0, rst = 1, flush_all = 0;
    logic        lfm_enable = 0, lfm_resolved;
    logic [31:0] lfm_addr = 0, lfm_word;
    logic        lsu_req = 0, lsu_we = 0, lsu_ack;
    logic [31:0] lsu_addr = 0, lsu_wdata = 0, lsu_rdata;
    logic [3:0]  lsu_wstrb = 0;
    logic        mem_req, mem_we, mem_ready = 0, bus_err, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] rd_val = 0;
    int          mem_delay = 0, wcnt = 0;
    int          vectors = 0, miscompares = 0, acks = 0;
    typedef struct { logic lsu; logic [31:0] data; logic err; } exp_t;
    exp_t        sb[$];

    ptw_mem_arbiter #(.TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .flush_all(flush_all),
        .lfm_enable(lfm_enable), .lfm_addr(lfm_addr), .lfm_resolved(lfm_resolved), .lfm_word(lfm_word),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_ack(lsu_ack), .lsu_rdata(lsu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err), .busy(busy)
    );

    always #5 clk = ~clk;
    assign mem_rdata = rd_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Memory answers mem_delay cycles into a request; reset with the DUT.
    always @(negedge clk) begin
        if (rst || !mem_req) begin
            wcnt = 0;
            mem_ready = 0;
        end else begin
            mem_ready = (wcnt == mem_delay);
            wcnt++;
        end
    end

    always @(negedge clk) begin
        if (!rst && (lfm_resolved || lsu_ack)) begin
            exp_t e;
            chk("both_pulses", {31'b0, lfm_resolved && lsu_ack}, 0);
            if (lsu_ack) acks++;
            if (sb.size() == 0) chk("unexpected_pulse", 1, 0);
            else begin
                e = sb.pop_front();
                chk("owner", {31'b0, lsu_ack}, {31'b0, e.lsu});
                chk("data", lsu_ack ? lsu_rdata : lfm_word, e.data);
                chk("bus_err", {31'b0, bus_err}, {31'b0, e.err});
            end
        end else if (!rst)
            chk("stray_err", {31'b0, bus_err}, 0);
    end

    task automatic wait_pulse(input string tag);
        int k;
        for (k = 0; k < 400 && !(lfm_resolved || lsu_ack); k++) step();
        if (k == 400) chk(tag, 0, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {25'b0, mem_req, mem_we, lfm_resolved, lsu_ack, bus_err, busy, |mem_wstrb}, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_word"}, lfm_word | lsu_rdata, 0);
    endtask

    initial begin
        int n;
        int k;
        repeat (3) step();
        rst = 0;
        step();
        chk_zero("reset");
        // Walker read, zero-wait memory: pulse two cycles after acceptance.
        rd_val = 32'h2000_0401; mem_delay = 0;
        lfm_enable = 1; lfm_addr = 32'h8000_1004;
        sb.push_back('{0, 32'h2000_0401, 0});
        step();
        chk("t1_req", {31'b0, mem_req}, 1);
        chk("t1_addr", mem_addr, 32'h8000_1004);
        chk("t1_we", {28'b0, mem_we, mem_wstrb[2:0]}, 0);
        step();
        chk("t1_latency", {31'b0, lfm_resolved}, 1);
        lfm_enable = 0;
        step();
        // Simultaneous walker read and store: walker first, then the store.
        rd_val = 32'h1234_5678; mem_delay = 2;
        lfm_enable = 1; lfm_addr = 32'h8000_3008;
        lsu_req = 1; lsu_we = 1; lsu_addr = 32'h8000_2000; lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 4'hF;
        sb.push_back('{0, 32'h1234_5678, 0});
        sb.push_back('{1, 32'h0, 0});
        for (k = 0; k < 20 && !lfm_resolved; k++) begin
            step();
            if (mem_req) chk("t2_mmu_addr", mem_addr, 32'h8000_3008);
        end
        chk("t2_mmu_done", {31'b0, lfm_resolved}, 1);
        lfm_enable = 0;
        step();
        chk("t2_gap", {31'b0, mem_req}, 0);
        step();
        chk("t2_st_req", {30'b0, mem_req, mem_we}, 3);
        chk("t2_st_addr", mem_addr, 32'h8000_2000);
        chk("t2_st_wdata", mem_wdata, 32'hCAFE_F00D);
        chk("t2_st_wstrb", {28'b0, mem_wstrb}, 32'hF);
        wait_pulse("t2_st_ack_timeout");
        lsu_req = 0; lsu_we = 0;
        repeat (3) step();
        chk("t2_ack_once", acks, 1);
        // Plain load with a few wait states.
        rd_val = 32'hDEAD_BEEF; mem_delay = 3;
        lsu_req = 1; lsu_addr = 32'h8000_0040; lsu_wstrb = 4'h0;
        sb.push_back('{1, 32'hDEAD_BEEF, 0});
        wait_pulse("t3_ack_timeout");
        lsu_req = 0;
        step();
        // Walker timeout: zero PTE with bus_err.
        rd_val = 32'hFFFF_FFFF; mem_delay = 1000;
        lfm_enable = 1; lfm_addr = 32'h8000_0FF8;
        sb.push_back('{0, 32'h0, 1});
        n = 0;
        for (k = 0; k < 300; k++) begin
            step();
            if (lfm_resolved) break;
            n += int'(mem_req);
        end
        chk("t4_req_cycles", n, 255);
        chk("t4_req_dropped", {31'b0, mem_req}, 0);
        lfm_enable = 0;
        step();
        // Flush during MEM: drain until memory answers, no ack.
        rd_val = 32'h5555_AAAA; mem_delay = 5;
        lsu_req = 1; lsu_we = 0; lsu_addr = 32'h8000_0100;
        step();
        chk("t5_req_c1", {31'b0, mem_req}, 1);
        step();
        flush_all = 1; lsu_req = 0;
        step();
        flush_all = 0;
        chk("t5_drain", {30'b0, mem_req, busy}, 3);
        n = 3;
        for (k = 0; k < 20; k++) begin
            step();
            if (!busy) break;
            n += int'(mem_req);
            chk("t5_addr_stable", mem_addr, 32'h8000_0100);
        end
        chk("t5_req_cycles", n, 6);
        chk("t5_idle", {31'b0, busy}, 0);
        mem_delay = 0;
        lsu_req = 1; lsu_we = 1; lsu_addr = 32'h8000_0200; lsu_wdata = 32'h0BAD_F00D; lsu_wstrb = 4'h3;
        sb.push_back('{1, 32'h0, 0});
        wait_pulse("t5_next_timeout");
        lsu_req = 0; lsu_we = 0;
        step();
        // Flush in RESP suppresses the pulse.
        rd_val = 32'h0000_0C01; mem_delay = 0;
        lfm_enable = 1; lfm_addr = 32'h8000_4000;
        step();
        @(posedge clk);
        #1 flush_all = 1; lfm_enable = 0;
        @(negedge clk);
        chk("t6_suppressed", {30'b0, lfm_resolved, busy}, 1);
        step();
        flush_all = 0;
        chk("t6_idle", {31'b0, busy}, 0);
        // Reset mid-MEM, then a normal walker read.
        mem_delay = 1000;
        lfm_enable = 1; lfm_addr = 32'h8000_5000;
        step();
        step();
        chk("t7_in_mem", {31'b0, mem_req}, 1);
        rst = 1; lfm_enable = 0;
        step();
        chk_zero("t7_reset");
        rst = 0;
        step();
        rd_val = 32'h0000_1001; mem_delay = 1;
        lfm_enable = 1; lfm_addr = 32'h8000_6000;
        sb.push_back('{0, 32'h0000_1001, 0});
        wait_pulse("t7_resolve_timeout");
        lfm_enable = 0;
        repeat (3) step();
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end
endmodule
